// File: rtl/piso_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The upstream word source drives the master side; the serializer takes the slave side.
interface piso_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;

  modport master (
    output din, din_valid,
    input  din_ready, ser_out, ser_valid, ser_last
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_out, ser_valid, ser_last
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding a SIPO; gapless reload on the last bit of a frame.
// Optional PISO_PARITY_EN appends an even-parity bit, making each frame WIDTH+1 bits.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  piso_if.slave  bus
);
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic             last_bit;
  logic             lead_bit;
  logic             ready;
  logic             load;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign last_bit      = (state_q == SHIFT) && (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign lead_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};
  // Ready comes only from registered state so the upstream sees no loop through din_valid.
  assign ready         = !rst && ((state_q == IDLE) || last_bit);
  assign load          = bus.din_valid && ready;

  assign bus.din_ready = ready;
  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.ser_last  = last_bit;
`ifdef PISO_PARITY_EN
  // Data bits are exhausted by the parity cycle, so the stored parity is muxed in.
  assign bus.ser_out   = (state_q == SHIFT) &&
                         ((cnt_q == CNT_W'(WIDTH)) ? parity_q : lead_bit);
`else
  assign bus.ser_out   = (state_q == SHIFT) && lead_bit;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = bus.din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_shifted;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (load) begin
            shreg_d = bus.din;
            state_d = SHIFT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PISO_PARITY_EN
    if (load) parity_d = ^bus.din;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus,
// checked by a hand-built vector table, then by a frame-queue model under random traffic.
module tb_piso_serializer;
  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_if #(.WIDTH(W)) bus0 ();
  piso_if #(.WIDTH(W)) bus1 ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(bus0));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic         r;
    logic         v;
    logic [W-1:0] d;
    logic         rdy;
    logic         vld;
    logic         lst;
    logic         o_msb;
    logic         o_lsb;
  } vec_t;

  vec_t vecs[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  bit   m_msb[$];
  bit   m_lsb[$];
  logic [W-1:0] sipo_l = '0;
  logic [W-1:0] sipo_r = '0;

  function automatic void add(logic r, logic v, logic [W-1:0] d, logic rdy, logic vld,
                              logic lst, logic om, logic ol);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.rdy = rdy; x.vld = vld; x.lst = lst; x.o_msb = om; x.o_lsb = ol;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic v, input logic [W-1:0] d);
    rst            = r;
    bus0.din_valid = v;
    bus0.din       = d;
    bus1.din_valid = v;
    bus1.din       = d;
    #1;
  endtask

  task automatic check_model();
    logic rdy;
    rdy = !rst && (m_msb.size() <= 1);
    chk("ready_msb", bus0.din_ready, rdy);
    chk("ready_lsb", bus1.din_ready, rdy);
    chk("valid_msb", bus0.ser_valid, m_msb.size() > 0);
    chk("valid_lsb", bus1.ser_valid, m_lsb.size() > 0);
    chk("last_msb",  bus0.ser_last,  m_msb.size() == 1);
    chk("last_lsb",  bus1.ser_last,  m_lsb.size() == 1);
    chk("out_msb",   bus0.ser_out,   (m_msb.size() > 0) ? m_msb[0] : 1'b0);
    chk("out_lsb",   bus1.ser_out,   (m_lsb.size() > 0) ? m_lsb[0] : 1'b0);
  endtask

  // Model: a frame is just the list of bits still to be sent; a transfer replaces it.
  task automatic advance();
    logic rdy;
    logic [W-1:0] d;
    rdy = !rst && (m_msb.size() <= 1);
    d   = bus0.din;
    if (bus0.ser_valid) sipo_l = {sipo_l[W-2:0], bus0.ser_out};
    if (bus1.ser_valid) sipo_r = {bus1.ser_out, sipo_r[W-1:1]};
    if (rst) begin
      m_msb.delete();
      m_lsb.delete();
    end else if (bus0.din_valid && rdy) begin
      m_msb.delete();
      m_lsb.delete();
      for (int i = 0; i < W; i++) begin
        m_msb.push_back(d[W-1-i]);
        m_lsb.push_back(d[i]);
      end
      if (FL > W) begin
        m_msb.push_back(^d);
        m_lsb.push_back(^d);
      end
    end else if (m_msb.size() > 0) begin
      void'(m_msb.pop_front());
      void'(m_lsb.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int sipo_l_idx;
    int sipo_r_idx;
    logic r, v;
    logic [W-1:0] d;

`ifdef PISO_PARITY_EN
    sipo_l_idx = -1;
    sipo_r_idx = -1;
    add(1, 0, 4'h0, 0, 0, 0, 0, 0);
    add(1, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0);
    add(0, 1, 4'h7, 1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 1, 0, 0, 1);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1);
    add(0, 0, 4'h0, 0, 1, 0, 1, 0);
    add(0, 0, 4'h0, 1, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0);
`else
    sipo_l_idx = 7;
    sipo_r_idx = 21;
    add(1, 0, 4'h0, 0, 0, 0, 0, 0);
    add(1, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0);
    add(0, 1, 4'hB, 1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1);
    add(0, 0, 4'h0, 0, 1, 0, 0, 1);
    add(0, 0, 4'h0, 0, 1, 0, 1, 0);
    add(0, 0, 4'h0, 1, 1, 1, 1, 1);
    add(0, 1, 4'hA, 1, 0, 0, 0, 0);
    add(0, 1, 4'h5, 0, 1, 0, 1, 0);
    add(0, 1, 4'h5, 0, 1, 0, 0, 1);
    add(0, 1, 4'h5, 0, 1, 0, 1, 0);
    add(0, 1, 4'h5, 1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 0, 1, 0, 0, 1);
    add(0, 0, 4'h0, 0, 1, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1, 0);
    add(0, 1, 4'h1, 1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 1, 0, 0, 1);
    add(0, 0, 4'h0, 0, 1, 0, 0, 0);
    add(0, 0, 4'h0, 0, 1, 0, 0, 0);
    add(0, 1, 4'hF, 1, 1, 1, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1);
    add(1, 0, 4'h0, 0, 1, 0, 1, 1);
    add(1, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0);
    add(1, 1, 4'hF, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0);
`endif

    apply(1'b1, 1'b0, '0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].v, vecs[i].d);
      chk("tbl_ready", bus0.din_ready, vecs[i].rdy);
      chk("tbl_ready_lsb", bus1.din_ready, vecs[i].rdy);
      chk("tbl_valid", bus0.ser_valid, vecs[i].vld);
      chk("tbl_last",  bus0.ser_last,  vecs[i].lst);
      chk("tbl_out_msb", bus0.ser_out, vecs[i].o_msb);
      chk("tbl_out_lsb", bus1.ser_out, vecs[i].o_lsb);
      advance();
      if (i == sipo_l_idx) begin
        vectors++;
        if (sipo_l !== 4'b1011) begin
          errors++;
          $display("FAIL sipo_left actual=%b required=1011", sipo_l);
        end
      end
      if (i == sipo_r_idx) begin
        vectors++;
        if (sipo_r !== 4'b0001) begin
          errors++;
          $display("FAIL sipo_right actual=%b required=0001", sipo_r);
        end
      end
    end

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = W'($urandom);
      apply(r, v, d);
      check_model();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out stage that sits directly upstream of the team's 4-bit SIPO shift register.
- Accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock on ser_out.
- ser_valid qualifies each bit, so ser_valid can drive the downstream SIPO's shift enable.
- Supports gapless back-to-back words: the next word is loaded during the last bit cycle of the current one.

Parameters:
- WIDTH, 4, word width in bits; legal values are 2 and above.
- MSB_FIRST, 1, bit order on the wire.
  - 1: din[WIDTH-1] goes out first. This pairs with the left-shift SIPO.
  - 0: din[0] goes out first. This pairs with the right-shift SIPO.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a valid bit this cycle.
- ser_last  output  1  current bit is the final bit of the frame.

Behaviour:
- Reset is clk with rst, synchronous, active-high. On reset:
  - state returns to IDLE; shift register and bit counter are cleared to 0.
  - ser_out=0, ser_valid=0, ser_last=0.
  - din_ready is forced to 0 while rst=1.
  - A frame in progress is abandoned with no further ser_valid.
- State machine has two states, IDLE and SHIFT.
- IDLE:
  - din_ready=1, ser_valid=0, ser_out=0.
  - din_valid=1 at the edge loads din into the shift register, sets cnt=0 and moves to SHIFT.
  - din_valid=0 stays in IDLE.
- SHIFT:
  - ser_valid=1.
  - ser_out is the register's leading bit: bit WIDTH-1 when MSB_FIRST=1, bit 0 when MSB_FIRST=0.
  - Each edge shifts the register by one toward the leading end, fills the vacated end with 0, and increments cnt.
- Last bit is cnt==FRAME_LEN-1, where FRAME_LEN=WIDTH without the optional feature.
  - On the last bit: ser_last=1 and din_ready=1.
  - din_valid=1 on that edge reloads the register, sets cnt=0 and stays in SHIFT. There is no idle cycle between frames.
  - din_valid=0 on that edge returns to IDLE.
- Handshake:
  - A transfer occurs only on an edge where din_valid and din_ready are both 1.
  - din_ready depends only on registered state and rst, never on din_valid.
  - din is sampled only on the transfer edge.
  - din_valid while din_ready=0 is ignored; the upstream must hold din_valid.
- Latency:
  - The first bit appears on ser_out in the cycle after the transfer edge.
  - A frame occupies exactly FRAME_LEN consecutive ser_valid cycles.
- Outputs ser_out, ser_valid and ser_last are derived from registers only, with no combinational path from inputs.
- rst asserted on the same edge as a transfer: reset wins and the word is dropped.
- cnt width is clog2(FRAME_LEN) bits.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all bits of the loaded word) is computed and stored at load time.
  - The parity bit is transmitted as one extra cycle after the WIDTH data bits, so FRAME_LEN=WIDTH+1.
  - ser_last and din_ready assert on the parity cycle, not on the last data bit.
- Not defined:
  - FRAME_LEN=WIDTH.
  - No parity logic or storage is synthesized.

Test Plan:
1. Reset, then idle. Hold rst=1 for 2 cycles, then release.
   - During rst: din_ready=0, ser_valid=0, ser_out=0.
   - Next cycle: din_ready=1.
2. Single word, WIDTH=4, MSB_FIRST=1. Transfer din=4'b1011.
   - Next 4 cycles: ser_out=1,0,1,1 with ser_valid=1; ser_last=1 only on the 4th bit.
   - Then IDLE.
   - A left-shift SIPO fed by ser_out and enabled by ser_valid holds Q=4'b1011.
3. Back-to-back. Words 4'hA then 4'h5 with din_valid held.
   - 8 consecutive ser_valid cycles: bits 1,0,1,0,0,1,0,1.
   - din_ready=1 only on cycles 4 and 8.
4. LSB first, MSB_FIRST=0. Transfer din=4'b0001.
   - ser_out=1,0,0,0.
   - A right-shift SIPO fed by ser_out holds Q=4'b0001.
5. Mid-frame reset. Load 4'hF, then assert rst after bit 2.
   - ser_valid=0 from the next cycle onward.
   - After release: IDLE with din_ready=1; no remaining bits are emitted.
6. Parity, with PISO_PARITY_EN defined. Transfer din=4'b0111.
   - 5 ser_valid cycles: 0,1,1,1 then parity bit 1.
   - ser_last=1 on the 5th cycle only.
